stepper_coil_model: RTL and testbench
=====================================

# stepper_coil_model

Behavioural bench model of one stepper-motor phase. It converts the four H-bridge gate signals from the microstepper into a signed coil-current estimate. It also measures the duty cycle of the matching current-reference PWM, so the bench can drive the chip's comparator input with `|current| >= duty`. Two instances (phase A and phase B) sit beside the chip in the top-level test environment.

## Interface
Parameters:
- `CHARGE_STEP`, default 2: current change per clock while the bridge drives the coil.
- `SLOW_DECAY`, default 1: decay per clock while both low-side switches are on, or both high-side switches are on.
- `FAST_DECAY`, default 4: decay per clock while all four switches are off.
- `DUTY_WINDOW`, default 4096: PWM measurement window in clocks; must be ≤ 4096.

Ports:
- `clk` in 1: single clock.
- `resetn` in 1: reset; asynchronous, active-low.
- `low_1`, `high_1` in 1: side-1 low/high switch gates; 1 = switch on.
- `low_2`, `high_2` in 1: side-2 low/high switch gates; 1 = switch on.
- `polarity_invert_config` in 1: when 1, the sign of the drive is negated.
- `pwm` in 1: current-reference PWM.
- `current` out 13, signed: modelled coil current; range −4095..+4095.
- `duty` out 13, unsigned: high-clock count over the last complete window; range 0..4096.
- `fault` out 1: sticky shoot-through flag.

## Operation
Bridge modes are decoded from the gates every clock. Priority, top to bottom:
- **Shoot-through** (`high_1 & low_1`, or `high_2 & low_2`): set `fault`; `current` is held.
- **Forward** (`high_1 & low_2`, with `high_2` and `low_1` off): drive = +1.
- **Reverse** (`high_2 & low_1`, with `high_1` and `low_2` off): drive = −1.
- **Slow decay** (`low_1 & low_2`, or `high_1 & high_2`): `|current|` shrinks by `SLOW_DECAY`.
- **All off**: `|current|` shrinks by `FAST_DECAY`.
- **Any other combination** (a single gate on): treated as all off.

Current update rules:
- The drive sign is negated when `polarity_invert_config` = 1.
- While driving: `current += drive·CHARGE_STEP`, saturating at ±4095.
- Decay moves `current` toward 0 and clamps at 0; it never crosses zero.
- All arithmetic uses 14-bit signed intermediates before saturation.

`fault`:
- Set to 1 on any shoot-through cycle.
- Cleared only by reset.

Duty measurement:
- A window counter runs 0..`DUTY_WINDOW`−1; a high counter counts cycles with `pwm` = 1.
- On the final cycle of the window, `duty` is loaded with the high count (that cycle included). Both counters then restart.
- A constant-high `pwm` gives `duty` = 4096, which is 13'h1000. Consumers that compare only the low 12 bits see 0; this is intended and documented.

## Timing
- Reset values: `current` = 0, `duty` = 0, `fault` = 0, both counters = 0.
- Reset is asynchronous: assertion clears all state immediately, including mid-window (the partial count is discarded). The first window after release starts at the first clock edge.
- `current` is registered, so a gate change takes effect on `current` one clock later.
- `duty` is registered: it is updated at the edge that ends the window and held constant for the next `DUTY_WINDOW` clocks.
- There is no handshake. The gates and `pwm` are sampled synchronously and assumed glitch-free relative to `clk`.

## Structure
- Shared package `coil_model_pkg` holds: `CURRENT_W` = 13, `CURRENT_MAX` = 4095, the bridge-mode enum (`SHOOT`, `FWD`, `REV`, `SLOW`, `OFF`), and the saturate/clamp function.
- One sub-module, `pwm_duty_meter` (`clk`, `resetn`, `pwm`, `duty`), containing the window and high counters.
- The top level holds the mode decoder and the current integrator.

## Test plan
- **Reset:** assert `resetn` = 0 mid-operation → `current` = 0, `duty` = 0, `fault` = 0 in the same cycle.
- **Forward drive and saturation:** from 0, hold `high_1` = `low_2` = 1 for 100 clocks → `current` = 200. Continue for 2000 more clocks → `current` = 4095, held there.
- **Inversion and reverse:**
  - With `polarity_invert_config` = 1, forward gates for 10 clocks from 0 → `current` = −20.
  - With `polarity_invert_config` = 0, `high_2` = `low_1` = 1 for 10 clocks from 0 → `current` = −20.
- **Decay:**
  - From 200, `low_1` = `low_2` = 1 for 50 clocks → `current` = 150.
  - From 10, all switches off for 5 clocks → `current` = 0, never negative.
- **Shoot-through:** from `current` = 50, set `high_1` = `low_1` = 1 for 1 clock → `fault` = 1 and `current` stays 50. `fault` stays 1 after the gates return to normal.
- **Duty:**
  - `pwm` high for 1024 of every 4096 clocks → `duty` = 1024 after the first full window.
  - `pwm` constantly 1 → `duty` = 4096.
  - `pwm` constantly 0 → `duty` = 0.

Source files
------------

// File: rtl/coil_model_pkg.sv
// -----------------------------------------------------------------------------
// coil_model_pkg
// Shared definitions for the stepper coil model: current width and limit,
// the bridge-mode enumeration, and the saturate / decay helpers used by the
// current integrator.
// -----------------------------------------------------------------------------
package coil_model_pkg;

    localparam int unsigned CURRENT_W   = 13;
    localparam int          CURRENT_MAX = 4095;

    // 14-bit signed limits used by the helpers below.
    localparam logic signed [CURRENT_W:0] SAT_HI = 14'sd4095;
    localparam logic signed [CURRENT_W:0] SAT_LO = -14'sd4095;

    typedef enum logic [2:0] {
        SHOOT,
        FWD,
        REV,
        SLOW,
        OFF
    } bridge_mode_e;

    // Clip a 14-bit intermediate into the legal +/-4095 current range.
    function automatic logic signed [CURRENT_W-1:0] sat_current(
        input logic signed [CURRENT_W:0] v
    );
        logic signed [CURRENT_W:0] w_clip;
        if (v > SAT_HI) begin
            w_clip = SAT_HI;
        end else if (v < SAT_LO) begin
            w_clip = SAT_LO;
        end else begin
            w_clip = v;
        end
        return w_clip[CURRENT_W-1:0];
    endfunction

    // Move a current toward zero by 'step' without ever crossing zero.
    function automatic logic signed [CURRENT_W-1:0] decay_current(
        input logic signed [CURRENT_W:0] cur,
        input logic signed [CURRENT_W:0] step
    );
        logic signed [CURRENT_W:0] w_res;
        if (cur > 14'sd0) begin
            w_res = cur - step;
            if (w_res < 14'sd0) begin
                w_res = 14'sd0;
            end
        end else if (cur < 14'sd0) begin
            w_res = cur + step;
            if (w_res > 14'sd0) begin
                w_res = 14'sd0;
            end
        end else begin
            w_res = 14'sd0;
        end
        return w_res[CURRENT_W-1:0];
    endfunction

endpackage

// File: rtl/pwm_duty_meter.sv
// -----------------------------------------------------------------------------
// pwm_duty_meter
// Counts the high cycles of a PWM input over a fixed window of DUTY_WINDOW
// clocks and publishes the count for the whole of the following window.
//
// Ports:
//   clk    in  : clock
//   resetn in  : asynchronous active-low reset
//   pwm    in  : PWM input, sampled every clock
//   duty   out : high-cycle count of the last complete window (0..4096)
// -----------------------------------------------------------------------------
module pwm_duty_meter #(
    parameter int unsigned DUTY_WINDOW = 4096
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        pwm,
    output logic [12:0] duty
);

    localparam logic [12:0] WIN_LAST = 13'(DUTY_WINDOW - 1);

    logic [12:0] r_win_cnt;
    logic [12:0] r_high_cnt;
    logic [12:0] r_duty;
    logic        w_win_last;
    logic [12:0] w_high_inc;

    assign w_win_last = (r_win_cnt == WIN_LAST);
    // Includes the current cycle, so the final cycle of a window is counted.
    assign w_high_inc = r_high_cnt + 13'(pwm);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_win_cnt  <= '0;
            r_high_cnt <= '0;
            r_duty     <= '0;
        end else if (w_win_last) begin
            r_win_cnt  <= '0;
            r_high_cnt <= '0;
            r_duty     <= w_high_inc;
        end else begin
            r_win_cnt  <= r_win_cnt + 13'd1;
            r_high_cnt <= w_high_inc;
        end
    end

    assign duty = r_duty;

endmodule

// File: rtl/stepper_coil_model.sv
// -----------------------------------------------------------------------------
// stepper_coil_model
// Behavioural model of one stepper-motor phase. Decodes the four H-bridge
// gates into a bridge mode, integrates a signed coil-current estimate, flags
// shoot-through, and measures the duty cycle of the current-reference PWM.
//
// Ports:
//   clk                    in  : clock
//   resetn                 in  : asynchronous active-low reset
//   low_1, high_1          in  : side-1 low/high switch gates (1 = on)
//   low_2, high_2          in  : side-2 low/high switch gates (1 = on)
//   polarity_invert_config in  : negate the drive sign when 1
//   pwm                    in  : current-reference PWM
//   current                out : signed coil current, -4095..+4095
//   duty                   out : PWM high count of the last window, 0..4096
//   fault                  out : sticky shoot-through flag
// -----------------------------------------------------------------------------
module stepper_coil_model
    import coil_model_pkg::*;
#(
    parameter int unsigned CHARGE_STEP = 2,
    parameter int unsigned SLOW_DECAY  = 1,
    parameter int unsigned FAST_DECAY  = 4,
    parameter int unsigned DUTY_WINDOW = 4096
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        low_1,
    input  logic                        high_1,
    input  logic                        low_2,
    input  logic                        high_2,
    input  logic                        polarity_invert_config,
    input  logic                        pwm,
    output logic signed [CURRENT_W-1:0] current,
    output logic [12:0]                 duty,
    output logic                        fault
);

    localparam logic signed [CURRENT_W:0] CHARGE_D = 14'(CHARGE_STEP);
    localparam logic signed [CURRENT_W:0] SLOW_D   = 14'(SLOW_DECAY);
    localparam logic signed [CURRENT_W:0] FAST_D   = 14'(FAST_DECAY);

    bridge_mode_e                w_mode;
    logic                        w_drive_pos;
    logic signed [CURRENT_W:0]   w_cur_ext;
    logic signed [CURRENT_W-1:0] w_current_nxt;
    logic signed [CURRENT_W-1:0] r_current;
    logic                        r_fault;

    // Mode decode in priority order; single-gate combinations fall to OFF.
    always_comb begin
        w_mode = OFF;
        if ((high_1 && low_1) || (high_2 && low_2)) begin
            w_mode = SHOOT;
        end else if (high_1 && low_2 && !high_2 && !low_1) begin
            w_mode = FWD;
        end else if (high_2 && low_1 && !high_1 && !low_2) begin
            w_mode = REV;
        end else if ((low_1 && low_2) || (high_1 && high_2)) begin
            w_mode = SLOW;
        end
    end

    assign w_drive_pos = (w_mode == FWD) ^ polarity_invert_config;
    assign w_cur_ext   = 14'(r_current);

    always_comb begin
        w_current_nxt = r_current;
        case (w_mode)
            FWD, REV: begin
                if (w_drive_pos) begin
                    w_current_nxt = sat_current(w_cur_ext + CHARGE_D);
                end else begin
                    w_current_nxt = sat_current(w_cur_ext - CHARGE_D);
                end
            end
            SLOW:    w_current_nxt = decay_current(w_cur_ext, SLOW_D);
            OFF:     w_current_nxt = decay_current(w_cur_ext, FAST_D);
            default: w_current_nxt = r_current;  // shoot-through holds
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_current <= '0;
            r_fault   <= 1'b0;
        end else begin
            r_current <= w_current_nxt;
            if (w_mode == SHOOT) begin
                r_fault <= 1'b1;
            end
        end
    end

    assign current = r_current;
    assign fault   = r_fault;

    pwm_duty_meter #(
        .DUTY_WINDOW (DUTY_WINDOW)
    ) u_duty (
        .clk    (clk),
        .resetn (resetn),
        .pwm    (pwm),
        .duty   (duty)
    );

endmodule

// File: tb/tb_stepper_coil_model.sv
module tb_stepper_coil_model;

    logic               clk = 1'b0;
    logic               resetn = 1'b0;
    logic               low_1 = 1'b0;
    logic               high_1 = 1'b0;
    logic               low_2 = 1'b0;
    logic               high_2 = 1'b0;
    logic               polarity_invert_config = 1'b0;
    logic               pwm = 1'b0;
    logic signed [12:0] current;
    logic [12:0]        duty;
    logic               fault;

    stepper_coil_model dut (
        .clk                    (clk),
        .resetn                 (resetn),
        .low_1                  (low_1),
        .high_1                 (high_1),
        .low_2                  (low_2),
        .high_2                 (high_2),
        .polarity_invert_config (polarity_invert_config),
        .pwm                    (pwm),
        .current                (current),
        .duty                   (duty),
        .fault                  (fault)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: plain integers.
    int m_cur   = 0;
    int m_fault = 0;
    int m_duty  = 0;
    int m_pos   = 0;
    int m_high  = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_gates(input logic h1, input logic l1, input logic h2, input logic l2);
        high_1 = h1;
        low_1  = l1;
        high_2 = h2;
        low_2  = l2;
    endtask

    // Apply the bridge rules to the model for one clock.
    task automatic model_clock();
        int d;
        int k;
        bit shoot;
        bit fwd;
        bit rev;
        bit slow;
        shoot = (high_1 && low_1) || (high_2 && low_2);
        fwd   = high_1 && low_2 && !high_2 && !low_1;
        rev   = high_2 && low_1 && !high_1 && !low_2;
        slow  = (low_1 && low_2) || (high_1 && high_2);
        if (shoot) begin
            m_fault = 1;
        end else if (fwd || rev) begin
            d = fwd ? 1 : -1;
            if (polarity_invert_config) d = -d;
            m_cur = m_cur + 2 * d;
            if (m_cur > 4095) m_cur = 4095;
            if (m_cur < -4095) m_cur = -4095;
        end else begin
            k = slow ? 1 : 4;
            if (m_cur > 0) m_cur = (m_cur > k) ? m_cur - k : 0;
            else if (m_cur < 0) m_cur = (-m_cur > k) ? m_cur + k : 0;
        end
        if (pwm) m_high++;
        m_pos++;
        if (m_pos == 4096) begin
            m_duty = m_high;
            m_high = 0;
            m_pos  = 0;
        end
    endtask

    // One clock: model steps with the edge, outputs checked 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_clock();
        #1;
        check_val("current", int'(current), m_cur);
        check_val("fault", int'(fault), m_fault);
        check_val("duty", int'(duty), m_duty);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Asynchronous reset applied mid-cycle, checked before any clock edge.
    task automatic do_reset();
        @(negedge clk);
        #2;
        resetn = 1'b0;
        set_gates(1'b0, 1'b0, 1'b0, 1'b0);
        pwm = 1'b0;
        polarity_invert_config = 1'b0;
        #1;
        check_val("rst_current", int'(current), 0);
        check_val("rst_duty", int'(duty), 0);
        check_val("rst_fault", int'(fault), 0);
        m_cur = 0;
        m_fault = 0;
        m_duty = 0;
        m_pos = 0;
        m_high = 0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        int g;
        do_reset();

        // Forward drive and saturation.
        set_gates(1'b1, 1'b0, 1'b0, 1'b1);
        steps(100);
        check_val("fwd_100", int'(current), 200);
        steps(2000);
        check_val("fwd_sat", int'(current), 4095);
        steps(20);
        check_val("fwd_sat_hold", int'(current), 4095);

        // Mid-window async reset with a partially counted pwm window.
        pwm = 1'b1;
        steps(500);
        do_reset();

        // Inverted forward, then plain reverse.
        polarity_invert_config = 1'b1;
        set_gates(1'b1, 1'b0, 1'b0, 1'b1);
        steps(10);
        check_val("inv_fwd", int'(current), -20);
        do_reset();
        set_gates(1'b0, 1'b1, 1'b1, 1'b0);
        steps(10);
        check_val("rev", int'(current), -20);

        // Slow decay 200 -> 150.
        do_reset();
        set_gates(1'b1, 1'b0, 1'b0, 1'b1);
        steps(100);
        set_gates(1'b0, 1'b1, 1'b0, 1'b1);
        steps(50);
        check_val("slow_decay", int'(current), 150);
        set_gates(1'b1, 1'b0, 1'b1, 1'b0);
        steps(10);
        check_val("slow_decay_hs", int'(current), 140);

        // Fast decay 10 -> 0 without going negative, negative side too.
        do_reset();
        set_gates(1'b1, 1'b0, 1'b0, 1'b1);
        steps(5);
        set_gates(1'b0, 1'b0, 1'b0, 1'b0);
        steps(5);
        check_val("fast_decay", int'(current), 0);
        set_gates(1'b0, 1'b1, 1'b1, 1'b0);
        steps(3);
        set_gates(1'b0, 1'b0, 1'b1, 1'b0);
        steps(3);
        check_val("single_gate_off", int'(current), 0);

        // Shoot-through holds current and sets a sticky fault.
        do_reset();
        set_gates(1'b1, 1'b0, 1'b0, 1'b1);
        steps(25);
        set_gates(1'b1, 1'b1, 1'b0, 1'b0);
        steps(1);
        check_val("shoot_fault", int'(fault), 1);
        check_val("shoot_hold", int'(current), 50);
        set_gates(1'b1, 1'b0, 1'b0, 1'b1);
        steps(1);
        check_val("fault_sticky", int'(fault), 1);
        check_val("after_shoot", int'(current), 52);

        // Duty: 1024 of 4096, constant high, constant low.
        do_reset();
        for (int i = 0; i < 4096; i++) begin
            pwm = (i < 1024);
            step();
        end
        check_val("duty_quarter", int'(duty), 1024);
        pwm = 1'b1;
        steps(4096);
        check_val("duty_full", int'(duty), 4096);
        pwm = 1'b0;
        steps(4096);
        check_val("duty_zero", int'(duty), 0);

        // Randomized gates, polarity and pwm against the model.
        do_reset();
        for (int i = 0; i < 9000; i++) begin
            g = $urandom_range(0, 15);
            // Keep shoot-through rare so the current path stays exercised.
            if ((((g & 3) == 3) || ((g & 12) == 12)) && ($urandom_range(0, 199) != 0)) begin
                g = 9;
            end
            set_gates(g[0], g[1], g[2], g[3]);
            if ($urandom_range(0, 63) == 0) polarity_invert_config = ~polarity_invert_config;
            pwm = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
